// File: rtl/mem_pkg.sv
// Shared memory-access definitions: store/load size codes, the store
// formatter state encoding, and the alignment rule for a sized access.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } store_state_e;

  // A request is unusable when the size is reserved or the address does
  // not sit on a boundary of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: drops the low byte or halfword
// of the source register into its lane of the old memory word.
module store_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  output logic [31:0] o_merged
);

  // Start from the old word and overwrite only the addressed lane(s).
  always_comb begin
    o_merged = i_old;
    case (i_size)
      SZ_BYTE: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_data[7:0];
          2'd1:    o_merged[15:8]  = i_data[7:0];
          2'd2:    o_merged[23:16] = i_data[7:0];
          default: o_merged[31:24] = i_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_lane[1]) o_merged[31:16] = i_data[15:0];
        else           o_merged[15:0]  = i_data[15:0];
      end
      SZ_WORD: o_merged = i_data;
      default: o_merged = i_old;
    endcase
  end

endmodule

// File: rtl/store_rmw.sv
// Store-side memory formatter: word stores go straight to a write, byte and
// halfword stores read the containing word, merge, and write it back.
// Misaligned or reserved-size requests are rejected without touching memory.
module store_rmw
  import mem_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iStart,
  input  logic [AWIDTH-1:0] iAddr,
  input  logic [DWIDTH-1:0] iData,
  input  logic [1:0]        iSize,
  output logic              oBusy,
  output logic              oDone,
  output logic              oAlignErr,
  output logic [AWIDTH-1:0] oMemAddr,
  output logic [DWIDTH-1:0] oMemWData,
  output logic              oMemRe,
  output logic              oMemWe,
  input  logic [DWIDTH-1:0] iMemRData,
  input  logic              iMemReady
);

  store_state_e      r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_data;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic [DWIDTH-1:0] w_merged;
  logic              w_misaligned;

  assign w_misaligned = misaligned(iSize, iAddr[1:0]);

  store_lane_merge u_merge (
    .i_old    (iMemRData),
    .i_data   (r_data),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .o_merged (w_merged)
  );

  // Request sequencing; address and write word are only loaded on accept
  // and on read completion, so they stay stable across READ/WRITE stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_size  <= SZ_BYTE;
      r_lane  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_addr <= {iAddr[AWIDTH-1:2], 2'b00};
            r_data <= iData;
            r_size <= iSize;
            r_lane <= iAddr[1:0];
            if (w_misaligned) begin
              r_state <= ST_ERR;
            end else if (iSize == SZ_WORD) begin
              r_wdata <= iData;
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (iMemReady) begin
            r_wdata <= w_merged;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (iMemReady) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the state register, so they cannot glitch
  // and Re/We are mutually exclusive by construction.
  assign oBusy     = (r_state != ST_IDLE);
  assign oDone     = (r_state == ST_DONE);
  assign oAlignErr = (r_state == ST_ERR);
  assign oMemRe    = (r_state == ST_READ);
  assign oMemWe    = (r_state == ST_WRITE);
  assign oMemAddr  = r_addr;
  assign oMemWData = r_wdata;

endmodule
